// File: rtl/palette_fade_ctrl.sv
// palette_fade_ctrl: 16-entry RGB444 palette with a two-stage brightness-scaled
// pixel path and a frame-paced fade sequencer for scene transitions.
module palette_fade_ctrl #(
    parameter int unsigned STEP_FRAMES = 4,
    parameter int unsigned NUM_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_pulse,
    input  logic        fade_out_req,
    input  logic        fade_in_req,
    output logic        busy,
    output logic [3:0]  level,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [11:0] cfg_data,
    input  logic        pix_valid,
    input  logic [3:0]  pix_index,
    output logic        pix_out_valid,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue
);

    typedef enum logic [1:0] {
        BRIGHT,
        FADING_OUT,
        DARK,
        FADING_IN
    } state_t;

    state_t      state;
    logic [7:0]  frame_cnt;
    logic [7:0]  frame_cnt_inc;
    logic        step_due;

    logic [11:0] pal [NUM_ENTRIES];
    logic        s1_valid;
    logic [11:0] s1_rgb;

    logic [4:0]  level_p1;
    logic [7:0]  prod_r;
    logic [7:0]  prod_g;
    logic [7:0]  prod_b;

    // Frame counting helpers shared by both fade directions
    always_comb begin
        frame_cnt_inc = frame_cnt + 8'd1;
        step_due      = (frame_cnt_inc == 8'(STEP_FRAMES));
    end

    // Fade sequencer: level steps once per STEP_FRAMES frame starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BRIGHT;
            level     <= 4'd15;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                BRIGHT: begin
                    if (fade_out_req) begin
                        state     <= FADING_OUT;
                        busy      <= 1'b1;
                        frame_cnt <= '0;
                    end
                end
                FADING_OUT: begin
                    if (vsync_pulse) begin
                        if (step_due) begin
                            frame_cnt <= '0;
                            level     <= level - 4'd1;
                            if (level == 4'd1) begin
                                state <= DARK;
                                busy  <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt_inc;
                        end
                    end
                end
                DARK: begin
                    if (fade_in_req) begin
                        state     <= FADING_IN;
                        busy      <= 1'b1;
                        frame_cnt <= '0;
                    end
                end
                FADING_IN: begin
                    if (vsync_pulse) begin
                        if (step_due) begin
                            frame_cnt <= '0;
                            level     <= level + 4'd1;
                            if (level == 4'd14) begin
                                state <= BRIGHT;
                                busy  <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= BRIGHT;
                    level <= 4'd15;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Palette storage; reset restores the grayscale ramp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                pal[i] <= {3{4'(i)}};
            end
        end else if (cfg_we) begin
            pal[cfg_addr] <= cfg_data;
        end
    end

    // Stage 1: palette lookup (same-edge write returns the old entry)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_rgb   <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_rgb   <= pal[pix_index];
        end
    end

    // Brightness scaling: c * (level + 1) in 8 bits, upper nibble kept
    always_comb begin
        level_p1 = {1'b0, level} + 5'd1;
        prod_r   = {4'b0000, s1_rgb[11:8]} * {3'b000, level_p1};
        prod_g   = {4'b0000, s1_rgb[7:4]}  * {3'b000, level_p1};
        prod_b   = {4'b0000, s1_rgb[3:0]}  * {3'b000, level_p1};
    end

    // Stage 2: scaled RGB output, forced to zero when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out_valid <= 1'b0;
            red           <= '0;
            green         <= '0;
            blue          <= '0;
        end else begin
            pix_out_valid <= s1_valid;
            if (s1_valid) begin
                red   <= prod_r[7:4];
                green <= prod_g[7:4];
                blue  <= prod_b[7:4];
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench for palette_fade_ctrl: table vectors, directed fade
// sequences, and randomized traffic against a behavioural reference model.
module tb_palette_fade_ctrl;

    localparam int STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        vsync_pulse;
    logic        fade_out_req;
    logic        fade_in_req;
    logic        busy;
    logic [3:0]  level;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        pix_valid;
    logic [3:0]  pix_index;
    logic        pix_out_valid;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;

    int checks = 0;
    int errors = 0;

    palette_fade_ctrl #(
        .STEP_FRAMES(STEP),
        .NUM_ENTRIES(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync_pulse  (vsync_pulse),
        .fade_out_req (fade_out_req),
        .fade_in_req  (fade_in_req),
        .busy         (busy),
        .level        (level),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .pix_valid    (pix_valid),
        .pix_index    (pix_index),
        .pix_out_valid(pix_out_valid),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Fade progress is tracked as "pulses counted since the fade began";
    // the level is derived from that count by division.
    int          m_pal [16];
    int          m_s1v, m_s1c;
    int          m_ov, m_orgb;
    int          m_level;
    int          m_fading;     // 0 idle, -1 fading down, +1 fading up
    int          m_start;      // level at fade start
    int          m_pulses;

    function automatic int scale(input int c, input int lvl);
        int r, g, b;
        r = ((c / 256) % 16) * (lvl + 1) / 16;
        g = ((c / 16) % 16) * (lvl + 1) / 16;
        b = (c % 16) * (lvl + 1) / 16;
        return r * 256 + g * 16 + b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = i * 273;
        m_s1v = 0; m_s1c = 0; m_ov = 0; m_orgb = 0;
        m_level = 15; m_fading = 0; m_start = 15; m_pulses = 0;
    endtask

    task automatic model_edge();
        int nov, norgb;
        nov   = m_s1v;
        norgb = m_s1v ? scale(m_s1c, m_level) : 0;
        m_s1v = int'(pix_valid);
        m_s1c = m_pal[pix_index];
        if (cfg_we) m_pal[cfg_addr] = int'(cfg_data);
        if (m_fading == 0) begin
            if (m_level == 15 && fade_out_req) begin
                m_fading = -1; m_start = 15; m_pulses = 0;
            end else if (m_level == 0 && fade_in_req) begin
                m_fading = 1; m_start = 0; m_pulses = 0;
            end
        end else if (vsync_pulse) begin
            m_pulses++;
            m_level = m_start + m_fading * (m_pulses / STEP);
            if (m_pulses == 15 * STEP) m_fading = 0;
        end
        m_ov = nov; m_orgb = norgb;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("pix_out_valid", int'(pix_out_valid), m_ov);
        chk("rgb", int'({red, green, blue}), m_orgb);
        chk("level", int'(level), m_level);
        chk("busy", int'(busy), (m_fading != 0) ? 1 : 0);
    endtask

    // One clock cycle: drive at negedge, model at posedge, compare at negedge
    task automatic cyc(input logic we, input logic [3:0] addr, input logic [11:0] data,
                       input logic pv, input logic [3:0] idx,
                       input logic vs, input logic fo, input logic fi);
        cfg_we = we; cfg_addr = addr; cfg_data = data;
        pix_valid = pv; pix_index = idx;
        vsync_pulse = vs; fade_out_req = fo; fade_in_req = fi;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
            idle();
        end
    endtask

    task automatic read_idx(input logic [3:0] idx, input int exp_rgb, input string name);
        cyc(1'b0, 4'd0, 12'h000, 1'b1, idx, 1'b0, 1'b0, 1'b0);
        idle();
        chk(name, int'({pix_out_valid, red, green, blue}), 4096 + exp_rgb);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [11:0] data;
        logic        pv;
        logic [3:0]  idx;
        logic        ev;      // expected pix_out_valid after this row's edge
        logic [11:0] ergb;    // expected RGB after this row's edge
    } vec_t;

    vec_t tbl [6];

    initial begin
        int exp_rgb;

        tbl[0] = '{1'b0, 4'd0, 12'h000, 1'b1, 4'd7, 1'b0, 12'h000};
        tbl[1] = '{1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b1, 12'h777};
        tbl[2] = '{1'b1, 4'd3, 12'h8D0, 1'b1, 4'd3, 1'b0, 12'h000};
        tbl[3] = '{1'b0, 4'd0, 12'h000, 1'b1, 4'd3, 1'b1, 12'h333};
        tbl[4] = '{1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b1, 12'h8D0};
        tbl[5] = '{1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 12'h000};

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        pix_valid = 1'b0; pix_index = '0;
        vsync_pulse = 1'b0; fade_out_req = 1'b0; fade_in_req = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_level", int'(level), 15);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(pix_out_valid), 0);
        chk("reset_rgb", int'({red, green, blue}), 0);
        rst_n = 1'b1;

        // Lookup latency, bubble, and write/read collision
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].pv, tbl[i].idx, 1'b0, 1'b0, 1'b0);
            chk($sformatf("tbl%0d_valid", i), int'(pix_out_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_rgb", i), int'({red, green, blue}), int'(tbl[i].ergb));
        end

        // Back-to-back stream of all indices at full brightness
        for (int i = 0; i < 18; i++) begin
            cyc(1'b0, 4'd0, 12'h000, (i < 16), 4'(i), 1'b0, 1'b0, 1'b0);
            if (i >= 1 && i <= 16) begin
                exp_rgb = (i - 1 == 3) ? 12'h8D0 : (i - 1) * 273;
                chk($sformatf("stream%0d", i - 1), int'({pix_out_valid, red, green, blue}),
                    4096 + exp_rgb);
            end
        end

        // Fade out: first step, mid-fade request immunity, reach black
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("fo_busy", int'(busy), 1);
        pulses(3);
        chk("fo_level_3p", int'(level), 15);
        pulses(1);
        chk("fo_level_4p", int'(level), 14);
        read_idx(4'd3, 12'h7C0, "lvl14_idx3");
        pulses(16);
        chk("fo_level_20p", int'(level), 10);
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("fo_ignore_busy", int'(busy), 1);
        pulses(39);
        chk("fo_dark_level", int'(level), 0);
        chk("fo_dark_busy", int'(busy), 0);
        for (int i = 0; i < 16; i++) read_idx(4'(i), 0, "dark_rgb");

        // Requests invalid in DARK are dropped; then fade back in
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("dark_fo_ignored", int'(busy), 0);
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1);
        chk("fi_busy", int'(busy), 1);
        pulses(59);
        chk("fi_level_59p", int'(level), 14);
        chk("fi_busy_59p", int'(busy), 1);
        pulses(1);
        chk("fi_level_60p", int'(level), 15);
        chk("fi_busy_60p", int'(busy), 0);

        // Second cycle down then partly up, then asynchronous reset
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("bright_fi_ignored", int'(busy), 0);
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        pulses(60);
        cyc(1'b0, 4'd0, 12'h000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        pulses(24);
        chk("pre_rst_level", int'(level), 6);
        cyc(1'b0, 4'd0, 12'h000, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", int'(level), 15);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(pix_out_valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        read_idx(4'd3, 12'h333, "post_rst_idx3");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 7) == 0), 4'($urandom), 12'($urandom),
                $urandom_range(0, 1) == 1, 4'($urandom),
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/palette_fade_ctrl.md
Name: palette_fade_ctrl

Overview:
Owns a writable 16-entry, 12-bit RGB palette and sequences whole-screen brightness fades for scene transitions.
- Pixel path: 4-bit colour index in; RGB444 out, scaled by the current brightness level through a 2-stage pipeline.
- Fade FSM: steps the brightness level once per STEP_FRAMES frame starts.
- Sits between the sprite/background index generators and the VGA output register.

Parameters:
STEP_FRAMES, 4, number of vsync_pulse events per brightness step (1..255)
NUM_ENTRIES, 16, palette depth; fixed at 16 because the index is 4 bits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
vsync_pulse  input  1  one-cycle strobe at each frame start
fade_out_req  input  1  one-cycle request to fade from full brightness to black
fade_in_req  input  1  one-cycle request to fade from black to full brightness
busy  output  1  high while a fade is in progress
level  output  4  current brightness; 15 = full, 0 = black
cfg_we  input  1  palette write enable
cfg_addr  input  4  palette write address
cfg_data  input  12  palette write data, {R,G,B} 4 bits each
pix_valid  input  1  pixel index valid
pix_index  input  4  pixel colour index
pix_out_valid  output  1  RGB valid; pix_valid delayed by 2 cycles
red  output  4  scaled red
green  output  4  scaled green
blue  output  4  scaled blue

Behaviour:
- One clock domain (clk). rst_n is asynchronous, active-low.
- Reset values:
  - FSM = BRIGHT, level = 15, frame counter = 0, busy = 0.
  - pix_out_valid = 0; red/green/blue = 0; pipeline valid bits = 0.
  - Palette entry i = {i,i,i} (grayscale ramp).
- Palette write: on a clk edge with cfg_we = 1, entry cfg_addr <= cfg_data. Writes are accepted in every FSM state.
- Write/read collision: a lookup sampled on the same edge as a write to the same address returns the OLD value. The new value is visible to lookups sampled on the next edge.
- Pixel pipeline:
  - Stage 1 registers the palette[pix_index] read and pix_valid.
  - Stage 2 registers each channel as (c * (level+1)) >> 4, using an 8-bit product and taking bits [7:4]. level 15 is identity; level 0 gives 0.
  - Stage 2 uses the level value present in that cycle.
  - Latency is exactly 2 cycles. Throughput is 1 pixel per cycle; no stalls.
  - When pix_out_valid = 0, RGB holds 0.
- FSM states:
  - BRIGHT: level = 15, busy = 0. fade_out_req -> FADING_OUT with frame counter cleared.
  - FADING_OUT: busy = 1. Each vsync_pulse increments the frame counter. When the counter reaches STEP_FRAMES: counter <= 0, level <= level - 1. The step that makes level 0 moves the FSM to DARK.
  - DARK: level = 0, busy = 0. fade_in_req -> FADING_IN with frame counter cleared.
  - FADING_IN: same counting as FADING_OUT, but level <= level + 1. The step that makes level 15 moves the FSM to BRIGHT.
- Request handling:
  - A request not valid in the current state is dropped, not queued. This covers fade_in_req in BRIGHT, fade_out_req in DARK, and any request while FADING.
  - When both requests arrive in the same cycle, only the state-valid one acts.
  - A request in the same cycle as vsync_pulse while in BRIGHT or DARK starts the fade; that vsync does not count.
- Full fade duration: 15 * STEP_FRAMES vsync pulses.
- level is a registered output and changes only on the edge that samples vsync_pulse.
- rst_n asserted mid-fade: immediate return to the reset state. The palette reverts to the grayscale ramp.

Test Plan:
1. After reset: pix_index = 7, pix_valid = 1 for one cycle -> two cycles later pix_out_valid = 1 and RGB = 7,7,7. The next cycle gives pix_out_valid = 0 and RGB = 0,0,0.
2. Write cfg_addr = 3, cfg_data = 0x8D0 while pix_index = 3 is presented in the same cycle -> output RGB = 3,3,3. Present index 3 again one cycle later -> RGB = 8,D,0.
3. STEP_FRAMES = 4, entry 3 = 0x8D0, pulse fade_out_req:
   - busy = 1 on the next cycle.
   - After 4 vsync pulses, level = 14 and index 3 -> RGB = 7,C,0.
   - After 60 pulses, level = 0, busy = 0, FSM = DARK, and every index -> RGB = 0,0,0.
4. While FADING_OUT at level 10, pulse fade_in_req and fade_out_req -> both ignored; the level sequence continues unchanged to 0. Then fade_in_req -> level reaches 15 after 60 pulses and busy drops.
5. Stream indices 0..15 back-to-back at level 15 -> 16 consecutive valid outputs equal to the palette contents, in order, with no gaps.
6. Assert rst_n low at level 6 during FADING_IN -> asynchronously level = 15, busy = 0, pix_out_valid = 0. After release, index 3 -> RGB = 3,3,3.
